// File: rtl/cpu_core.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_core: tiny accumulator-free register CPU with program RAM and I/O       |
// | handshakes. Rev 1.0 -- initial release.                                     |
// +----------------------------------------------------------------------------+
module cpu_core #(
  parameter int BUS_WIDTH        = 8,
  parameter int INSTR_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH   = 2,
  localparam int INSTR_WIDTH     = 4 + 2*REG_ADDR_WIDTH + BUS_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        prog_we,
  input  logic [INSTR_ADDR_WIDTH-1:0] prog_addr,
  input  logic [INSTR_WIDTH-1:0]      prog_data,
  input  logic [BUS_WIDTH-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [BUS_WIDTH-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        halted,
  output logic [INSTR_ADDR_WIDTH-1:0] pc
);

  localparam int PROG_DEPTH = 2**INSTR_ADDR_WIDTH;
  localparam int NUM_REGS   = 2**REG_ADDR_WIDTH;

  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_MOV  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_IN   = 4'd6;
  localparam logic [3:0] OP_OUT  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_JNZ  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    HALT     = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    WAIT_IN  = 3'd3,
    WAIT_OUT = 3'd4
  } state_t;

  state_t state, state_next;

  logic [INSTR_WIDTH-1:0]      mem [PROG_DEPTH];
  logic [BUS_WIDTH-1:0]        regs [NUM_REGS];
  logic [INSTR_WIDTH-1:0]      ir;
  logic [3:0]                  opcode;
  logic [REG_ADDR_WIDTH-1:0]   rd, rs;
  logic [BUS_WIDTH-1:0]        imm, rd_val, rs_val, wb_data;
  logic [INSTR_ADDR_WIDTH-1:0] pc_next, pc_inc, jmp_target;
  logic                        wb_en;

  assign opcode     = ir[INSTR_WIDTH-1 -: 4];
  assign rd         = ir[INSTR_WIDTH-5 -: REG_ADDR_WIDTH];
  assign rs         = ir[INSTR_WIDTH-5-REG_ADDR_WIDTH -: REG_ADDR_WIDTH];
  assign imm        = ir[BUS_WIDTH-1:0];
  assign rd_val     = (rd == '0) ? '0 : regs[rd];
  assign rs_val     = (rs == '0) ? '0 : regs[rs];
  assign pc_inc     = pc + 1'b1;
  assign jmp_target = imm[INSTR_ADDR_WIDTH-1:0];

  assign halted    = (state == HALT);
  assign in_ready  = (state == WAIT_IN);
  assign out_valid = (state == WAIT_OUT);

  // Program RAM has no reset so a loaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= HALT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    wb_en      = 1'b0;
    wb_data    = rd_val;
    case (state)
      HALT: if (start) begin
        state_next = FETCH;
        pc_next    = '0;
      end
      FETCH: state_next = EXEC;
      EXEC: begin
        state_next = FETCH;
        pc_next    = pc_inc;
        case (opcode)
          OP_LDI:  begin wb_en = 1'b1; wb_data = imm; end
          OP_MOV:  begin wb_en = 1'b1; wb_data = rs_val; end
          OP_ADD:  begin wb_en = 1'b1; wb_data = rd_val + rs_val; end
          OP_SUB:  begin wb_en = 1'b1; wb_data = rd_val - rs_val; end
          OP_ADDI: begin wb_en = 1'b1; wb_data = rd_val + imm; end
          OP_IN:   begin state_next = WAIT_IN;  pc_next = pc; end
          OP_OUT:  begin state_next = WAIT_OUT; pc_next = pc; end
          OP_JMP:  pc_next = jmp_target;
          OP_JZ:   if (rs_val == '0) pc_next = jmp_target;
          OP_JNZ:  if (rs_val != '0) pc_next = jmp_target;
          OP_HALT: begin state_next = HALT; pc_next = pc; end
          default: ;
        endcase
      end
      WAIT_IN: if (in_valid) begin
        state_next = FETCH;
        pc_next    = pc_inc;
        wb_en      = 1'b1;
        wb_data    = in_data;
      end
      WAIT_OUT: if (out_ready) begin
        state_next = FETCH;
        pc_next    = pc_inc;
      end
      default: state_next = HALT;
    endcase
  end

  // Nonblocking read of mem gives read-before-write against a same-cycle program write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      ir       <= '0;
      out_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (state == FETCH) ir <= mem[pc];
      if (state == EXEC && opcode == OP_OUT) out_data <= rs_val;
      if (wb_en && rd != '0) regs[rd] <= wb_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_core: scoreboard bench with an ISA-level reference interpreter.      |
// | Rev 1.0 -- initial release.                                                 |
// +----------------------------------------------------------------------------+
module tb_cpu_core;

  localparam int BW    = 8;
  localparam int IAW   = 4;
  localparam int RAW   = 2;
  localparam int IW    = 4 + 2*RAW + BW;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           reset, start, prog_we;
  logic [IAW-1:0] prog_addr;
  logic [IW-1:0]  prog_data;
  logic [BW-1:0]  in_data;
  logic           in_valid, in_ready;
  logic [BW-1:0]  out_data;
  logic           out_valid, out_ready;
  logic           halted;
  logic [IAW-1:0] pc;

  always #5 clk = ~clk;

  cpu_core #(.BUS_WIDTH(BW), .INSTR_ADDR_WIDTH(IAW), .REG_ADDR_WIDTH(RAW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .pc(pc)
  );

  int            checks = 0;
  int            failures = 0;
  logic [BW-1:0] exp_out[$];
  logic [BW-1:0] in_q[$];
  logic [IW-1:0] prog [DEPTH];
  logic [BW-1:0] mregs [4];
  int            exp_pc;
  logic [BW-1:0] last_exp;
  bit            have_last;
  bit            hold_ready_lo = 1'b0;
  bit            hold_valid_lo = 1'b0;
  bit            in_hs;
  bit            prev_valid = 1'b0;
  bit            prev_hs = 1'b0;
  logic [BW-1:0] prev_data;
  logic [BW-1:0] popped;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [IW-1:0] ins(input int op, input int rd, input int rs, input int imm);
    return {op[3:0], rd[1:0], rs[1:0], imm[7:0]};
  endfunction

  function automatic void mwr(input int rd, input int v);
    if (rd != 0) mregs[rd] = v[7:0];
  endfunction

  // Instruction-set interpreter: produces expected outputs, input values and final pc.
  task automatic model_run();
    int p = 0;
    int op, rd, rs, imm, a, b, v;
    logic [IW-1:0] w;
    for (int steps = 0; steps < 1000; steps++) begin
      w   = prog[p];
      op  = int'(w[15:12]);
      rd  = int'(w[11:10]);
      rs  = int'(w[9:8]);
      imm = int'(w[7:0]);
      a   = (rd == 0) ? 0 : int'(mregs[rd]);
      b   = (rs == 0) ? 0 : int'(mregs[rs]);
      if (op == 15) break;
      case (op)
        1: mwr(rd, imm);
        2: mwr(rd, b);
        3: mwr(rd, (a + b) % 256);
        4: mwr(rd, (a - b + 256) % 256);
        5: mwr(rd, (a + imm) % 256);
        6: begin
          v = int'($urandom_range(0, 255));
          in_q.push_back(v[7:0]);
          mwr(rd, v);
        end
        7: begin
          exp_out.push_back(b[7:0]);
          last_exp  = b[7:0];
          have_last = 1'b1;
        end
        default: ;
      endcase
      if (op == 8 || (op == 9 && b == 0) || (op == 10 && b != 0)) p = imm % DEPTH;
      else p = (p + 1) % DEPTH;
    end
    exp_pc = p;
  endtask

  // Program is written while reset is held, so loading also exercises write-during-reset.
  task automatic load_prog();
    reset = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      prog_we   = 1'b1;
      prog_addr = IAW'(a);
      prog_data = prog[a];
      @(posedge clk); #1;
    end
    prog_we = 1'b0;
    reset   = 1'b0;
    foreach (mregs[i]) mregs[i] = '0;
    exp_out.delete();
    in_q.delete();
    have_last = 1'b0;
  endtask

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = '0;
  endtask

  task automatic start_prog();
    model_run();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (halted) break;
      n++;
    end
    check({name, "_halt_timeout"}, 32'(n >= 3000), 32'd0);
    check({name, "_final_pc"}, 32'(pc), 32'(exp_pc));
    check({name, "_outputs_left"}, 32'(exp_out.size()), 32'd0);
    check({name, "_inputs_left"}, 32'(in_q.size()), 32'd0);
    if (have_last) check({name, "_out_data_retained"}, 32'(out_data), 32'(last_exp));
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks data stability.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && prev_valid && !prev_hs)
        check("out_data_stable", 32'(out_data), 32'(prev_data));
      prev_hs = out_valid && out_ready;
      if (prev_hs) begin
        if (exp_out.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: actual=%0h required=none", out_data);
        end else begin
          popped = exp_out.pop_front();
          check("out_data", 32'(out_data), 32'(popped));
        end
      end
      prev_valid = out_valid;
      prev_data  = out_data;
    end
  end

  // Handshake driver: random ready/valid, input data taken from the model's queue.
  initial begin
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    forever begin
      @(negedge clk);
      in_hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (in_hs && in_q.size() > 0) void'(in_q.pop_front());
      out_ready = hold_ready_lo ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (in_q.size() > 0 && !hold_valid_lo) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = in_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = BW'($urandom);
      end
    end
  end

  initial begin
    int n;
    int op, tgt;
    reset     = 1'b1;
    start     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    @(posedge clk); #1;

    // Sum program, loaded under reset, then reset-state checks.
    clear_prog();
    prog[0] = ins(1, 1, 0, 5);
    prog[1] = ins(1, 2, 0, 3);
    prog[2] = ins(3, 1, 2, 0);
    prog[3] = ins(7, 0, 1, 0);
    prog[4] = ins(15, 0, 0, 0);
    load_prog();
    @(negedge clk);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    hold_ready_lo = 1'b1;
    start_prog();
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_to_out_valid", 32'(n), 32'd8);
    repeat (5) begin
      @(negedge clk);
      check("out_valid_held", 32'(out_valid), 32'd1);
    end
    hold_ready_lo = 1'b0;
    wait_halt("sum");

    // Wrap-around arithmetic.
    clear_prog();
    prog[0] = ins(1, 1, 0, 8'hFF);
    prog[1] = ins(5, 1, 0, 2);
    prog[2] = ins(7, 0, 1, 0);
    prog[3] = ins(1, 2, 0, 1);
    prog[4] = ins(4, 3, 2, 0);
    prog[5] = ins(7, 0, 3, 0);
    prog[6] = ins(15, 0, 0, 0);
    load_prog();
    start_prog();
    wait_halt("wrap");

    // Input wait with in_valid withheld.
    clear_prog();
    prog[0] = ins(6, 1, 0, 0);
    prog[1] = ins(7, 0, 1, 0);
    prog[2] = ins(15, 0, 0, 0);
    load_prog();
    hold_valid_lo = 1'b1;
    start_prog();
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_reached", 32'(n < 50), 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("in_ready_wait", 32'(in_ready), 32'd1);
    end
    hold_valid_lo = 1'b0;
    wait_halt("input");

    // Countdown loop.
    clear_prog();
    prog[0] = ins(1, 1, 0, 3);
    prog[1] = ins(5, 1, 0, 8'hFF);
    prog[2] = ins(10, 0, 1, 1);
    prog[3] = ins(7, 0, 1, 0);
    prog[4] = ins(15, 0, 0, 0);
    load_prog();
    start_prog();
    wait_halt("loop");

    // Jump to last address, pc wraps to 0.
    clear_prog();
    prog[0]  = ins(10, 0, 1, 3);
    prog[1]  = ins(1, 1, 0, 1);
    prog[2]  = ins(8, 0, 0, 8'hAF);
    prog[3]  = ins(7, 0, 1, 0);
    prog[4]  = ins(15, 0, 0, 0);
    prog[15] = ins(5, 1, 0, 1);
    load_prog();
    start_prog();
    wait_halt("pc_wrap");

    // Reset while waiting to output, then rerun from intact memory.
    clear_prog();
    prog[0] = ins(1, 1, 0, 5);
    prog[1] = ins(1, 2, 0, 3);
    prog[2] = ins(3, 1, 2, 0);
    prog[3] = ins(7, 0, 1, 0);
    prog[4] = ins(15, 0, 0, 0);
    load_prog();
    hold_ready_lo = 1'b1;
    start_prog();
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_halted", 32'(halted), 32'd1);
    check("midrst_pc", 32'(pc), 32'd0);
    exp_out.delete();
    foreach (mregs[i]) mregs[i] = '0;
    have_last     = 1'b0;
    hold_ready_lo = 1'b0;
    start_prog();
    wait_halt("rerun");

    // Random forward-branching programs.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        op = int'($urandom_range(0, 14));
        if (op >= 8 && op <= 10) begin
          tgt     = int'($urandom_range(i + 1, DEPTH - 1));
          prog[i] = ins(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 15)) * 16 + tgt);
        end else begin
          prog[i] = ins(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 255)));
        end
      end
      prog[DEPTH-1] = ins(15, 0, 0, 0);
      load_prog();
      start_prog();
      wait_halt("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, meaning datapath and register width.
REQ-002 SHALL have parameter INSTR_ADDR_WIDTH, default 4, meaning program counter width; program depth is 2**INSTR_ADDR_WIDTH; legal only if INSTR_ADDR_WIDTH <= BUS_WIDTH.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 2, meaning register file depth of 2**REG_ADDR_WIDTH.
REQ-004 SHALL derive INSTR_WIDTH = 4 + 2*REG_ADDR_WIDTH + BUS_WIDTH; fields from MSB: opcode[3:0], rd, rs, imm.
REQ-005 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have start, input, 1, begins execution at address 0 when halted.
REQ-008 SHALL have prog_we, input, 1; prog_addr, input, INSTR_ADDR_WIDTH; prog_data, input, INSTR_WIDTH: program memory write port.
REQ-009 SHALL have in_data, input, BUS_WIDTH; in_valid, input, 1; in_ready, output, 1: input handshake.
REQ-010 SHALL have out_data, output, BUS_WIDTH; out_valid, output, 1; out_ready, input, 1: output handshake.
REQ-011 SHALL have halted, output, 1, and pc, output, INSTR_ADDR_WIDTH.

Function
REQ-012 SHALL implement FSM states HALT, FETCH, EXEC, WAIT_IN, WAIT_OUT; halted=1 only in HALT.
REQ-013 HALT: start=1 -> pc<=0, FETCH; start ignored in all other states.
REQ-014 FETCH: instruction register <= mem[pc] (synchronous read), -> EXEC; each non-waiting instruction takes exactly 2 cycles.
REQ-015 EXEC opcodes: 0 NOP; 1 LDI rd<=imm; 2 MOV rd<=rs; 3 ADD rd<=rd+rs; 4 SUB rd<=rd-rs; 5 ADDI rd<=rd+imm; 6 IN; 7 OUT; 8 JMP; 9 JZ; 10 JNZ; 15 HALT; 11-14 execute as NOP.
REQ-016 Arithmetic SHALL wrap modulo 2**BUS_WIDTH; no flags stored.
REQ-017 Register 0 SHALL read as zero; writes to register 0 are discarded.
REQ-018 Non-branch EXEC: pc<=pc+1, wrapping from 2**INSTR_ADDR_WIDTH-1 to 0; -> FETCH.
REQ-019 JMP: pc<=imm[INSTR_ADDR_WIDTH-1:0]; JZ taken iff rs==0, JNZ taken iff rs!=0; not taken -> pc+1; -> FETCH.
REQ-020 HALT opcode: pc unchanged, -> HALT.
REQ-021 IN: EXEC -> WAIT_IN; in_ready=1 only in WAIT_IN; on in_valid&in_ready rd<=in_data, pc<=pc+1, -> FETCH; in_valid before WAIT_IN is not consumed.
REQ-022 OUT: EXEC -> WAIT_OUT with out_data<=rs; out_valid=1 only in WAIT_OUT; out_data held stable while out_valid=1; on out_valid&out_ready pc<=pc+1, -> FETCH.
REQ-023 out_data SHALL retain the last transferred value after out_valid falls.
REQ-024 prog_we SHALL write mem[prog_addr]<=prog_data in any state; same-cycle write to the address being fetched returns old data (read-before-write).
REQ-025 Program memory contents SHALL not be cleared by reset.

Reset
REQ-026 On reset=1 at a clock edge: state<=HALT, pc<=0, all registers<=0, instruction register<=0, out_data<=0; out_valid=0, in_ready=0, halted=1 from the following cycle.
REQ-027 Reset SHALL take priority over start, handshakes and prog_we-independent state; reset mid-WAIT_IN/WAIT_OUT abandons the transfer with no register write.
REQ-028 prog_we SHALL remain functional while reset is asserted.

Verification
REQ-029 Load LDI r1,5; LDI r2,3; ADD r1,r2; OUT r1; HALT; start -> out_valid rises 7 cycles after start edge+1, out_data=8, then halted=1.
REQ-030 LDI r1,0xFF; ADDI r1,2; OUT r1 -> out_data=0x01 (wrap); SUB r0-based: LDI r2,1; SUB r3(=0),r2 -> r3=0xFF.
REQ-031 IN r1 with in_valid=0 for 10 cycles then in_data=0x2A,in_valid=1 -> in_ready high throughout wait, r1=0x2A, OUT r1 gives 0x2A.
REQ-032 OUT with out_ready=0 for 5 cycles -> out_valid and out_data stable for all 5, single transfer when out_ready=1.
REQ-033 Loop LDI r1,3; ADDI r1,0xFF; JNZ r1,1; HALT -> exactly 3 passes, halted with r1=0; JMP 15 followed by non-branch at 15 -> pc wraps to 0.
REQ-034 Assert reset during WAIT_OUT -> next cycle out_valid=0, out_data=0, halted=1, pc=0; start reruns program from address 0 with memory intact.
